// File: rtl/rps_pkg.sv
// Shared definitions for the round controller: state encoding and default sizing.
package rps_pkg;

  localparam int DATA_W_DEF     = 5;
  localparam int SCORE_W_DEF    = 8;
  localparam int LIVES_INIT_DEF = 3;
  localparam int TIMEOUT_DEF    = 1000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GET_X  = 3'd1;
  localparam logic [2:0] ST_GET_Y  = 3'd2;
  localparam logic [2:0] ST_EVAL   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    GET_X  = ST_GET_X,
    GET_Y  = ST_GET_Y,
    EVAL   = ST_EVAL,
    UPDATE = ST_UPDATE,
    OVER   = ST_OVER
  } state_e;

endpackage

// File: rtl/round_controller_if.sv
// Entry port between the input/debounce logic (master) and the round controller (slave).
interface round_controller_if
  import rps_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] in_value;
  logic              in_ready;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/round_timer.sv
// Per-entry timeout counter: clear wins over enable; expire flags the last allowed cycle.
module round_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == TW'(TIMEOUT - 1));
endmodule

// File: rtl/round_controller.sv
// Game sequencer: collects two entries per round, latches the ALU verdict and
// applies it to score/lives. All outputs are registered.
module round_controller
  import rps_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int LIVES_INIT = LIVES_INIT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  round_controller_if.slave  in_if,
  output logic [DATA_W-1:0]  alu_x,
  output logic [DATA_W-1:0]  alu_y,
  input  logic               alu_lose,
  input  logic [DATA_W-1:0]  alu_bonus,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               round_done,
  output logic               game_over,
  output logic               busy
);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [DATA_W-1:0]  b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W + 1)'(b);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  alu_x_q, alu_y_q;
  logic [SCORE_W-1:0] score_q;
  logic [1:0]         lives_q;
  logic               in_ready_q, round_done_q, game_over_q, busy_q;
  logic               lose_q;
  logic [DATA_W-1:0]  bonus_q;

  logic in_get, accept, expire;

  assign in_get = (state_q == GET_X) || (state_q == GET_Y);
  assign accept = in_if.in_valid && in_ready_q;

  round_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (accept || !in_get),
    .en_i     (in_get),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start) state_d = GET_X;
      GET_X:      if (accept) state_d = GET_Y; else if (expire) state_d = UPDATE;
      GET_Y:      if (accept) state_d = EVAL;  else if (expire) state_d = UPDATE;
      EVAL:       state_d = UPDATE;
      UPDATE:     state_d = (lose_q && lives_q == 2'd1) ? OVER : GET_X;
      default:    state_d = IDLE;
    endcase
  end

  // Control and visible state; outputs are decoded from the next state so they
  // line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      score_q      <= '0;
      lives_q      <= '0;
      in_ready_q   <= 1'b0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == GET_X) || (state_d == GET_Y);
      round_done_q <= (state_d == UPDATE);
      game_over_q  <= (state_d == OVER);
      busy_q       <= (state_d != IDLE) && (state_d != OVER);
      case (state_q)
        IDLE, OVER: if (start) begin
          score_q <= '0;
          lives_q <= 2'(LIVES_INIT);
        end
        GET_X:  if (accept) alu_x_q <= in_if.in_value;
        GET_Y:  if (accept) alu_y_q <= in_if.in_value;
        UPDATE: if (lose_q) lives_q <= lives_q - 2'd1;
                else        score_q <= sat_add(score_q, bonus_q);
        default: ;
      endcase
    end
  end

  // Round verdict: from the ALU in EVAL, forced to a loss on entry timeout.
  always_ff @(posedge clk) begin
    if (state_q == EVAL) begin
      lose_q  <= alu_lose;
      bonus_q <= alu_bonus;
    end else if (in_get && !accept && expire) begin
      lose_q  <= 1'b1;
      bonus_q <= '0;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign alu_x          = alu_x_q;
  assign alu_y          = alu_y_q;
  assign score          = score_q;
  assign lives          = lives_q;
  assign round_done     = round_done_q;
  assign game_over      = game_over_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with a behavioural comparator/subtractor ALU.
module tb_round_controller;
  localparam int DATA_W  = 5;
  localparam int SCORE_W = 8;
  localparam int TMO     = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic force_lose = 1'b0;
  logic [DATA_W-1:0]  alu_x, alu_y, alu_bonus;
  logic               alu_lose;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               round_done, game_over, busy;
  int checks = 0;
  int errors = 0;

  round_controller_if #(.DATA_W(DATA_W)) bus ();

  round_controller #(.DATA_W(DATA_W), .SCORE_W(SCORE_W), .LIVES_INIT(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_if(bus),
    .alu_x(alu_x), .alu_y(alu_y), .alu_lose(alu_lose), .alu_bonus(alu_bonus),
    .score(score), .lives(lives), .round_done(round_done),
    .game_over(game_over), .busy(busy)
  );

  assign alu_lose  = force_lose | (alu_x == alu_y);
  assign alu_bonus = (alu_x > alu_y) ? alu_x - alu_y : alu_y - alu_x;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    int n;
    bus.in_valid = 1'b1;
    bus.in_value = v;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_ready got 0 want 1 (value %0d)", v);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic play_round(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    send(a); send(b); tick(); tick(); tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d want 0", score); end
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL rst_lives got %0d want 0", lives); end
    checks++; if ({bus.in_ready, round_done, game_over, busy} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {bus.in_ready, round_done, game_over, busy}); end
    checks++; if ({alu_x, alu_y} !== 10'd0) begin errors++; $display("FAIL rst_alu got %0d/%0d want 0/0", alu_x, alu_y); end
  endtask

  task automatic test_first_round();
    pulse_start();
    checks++; if ({bus.in_ready, busy, lives} !== 4'b1111) begin errors++; $display("FAIL start_state got %b want 1111", {bus.in_ready, busy, lives}); end
    send(5'd9);
    checks++; if (alu_x !== 5'd9) begin errors++; $display("FAIL r1_alu_x got %0d want 9", alu_x); end
    send(5'd4);
    checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL r1_done_early got %b want 0", round_done); end
    tick();
    checks++; if ({round_done, score} !== {1'b1, 8'd0}) begin errors++; $display("FAIL r1_done got %b/%0d want 1/0", round_done, score); end
    tick();
    checks++; if ({round_done, score, lives} !== {1'b0, 8'd5, 2'd3}) begin errors++; $display("FAIL r1_result got %b/%0d/%0d want 0/5/3", round_done, score, lives); end
  endtask

  task automatic test_lose_to_over();
    play_round(5'd7, 5'd7);
    checks++; if ({score, lives} !== {8'd5, 2'd2}) begin errors++; $display("FAIL lose1 got %0d/%0d want 5/2", score, lives); end
    play_round(5'd7, 5'd7);
    checks++; if (lives !== 2'd1) begin errors++; $display("FAIL lose2 got %0d want 1", lives); end
    play_round(5'd7, 5'd7);
    checks++; if ({game_over, busy, bus.in_ready, lives, score} !== {3'b100, 2'd0, 8'd5}) begin errors++; $display("FAIL over got go=%b busy=%b rdy=%b lives=%0d score=%0d want 1 0 0 0 5", game_over, busy, bus.in_ready, lives, score); end
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < 8; i++) play_round(5'd31, 5'd0);
    play_round(5'd2, 5'd0);
    checks++; if (score !== 8'd250) begin errors++; $display("FAIL sat_pre got %0d want 250", score); end
    play_round(5'd31, 5'd0);
    checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat got %0d want 255", score); end
    play_round(5'd31, 5'd0);
    checks++; if ({score, lives} !== {8'd255, 2'd3}) begin errors++; $display("FAIL sat_hold got %0d/%0d want 255/3", score, lives); end
  endtask

  task automatic test_timeout();
    send(5'd10);
    for (int i = 0; i < TMO - 1; i++) tick();
    checks++; if ({bus.in_ready, round_done} !== 2'b10) begin errors++; $display("FAIL tmo_edge got %b want 10", {bus.in_ready, round_done}); end
    tick();
    checks++; if ({bus.in_ready, round_done} !== 2'b01) begin errors++; $display("FAIL tmo_update got %b want 01", {bus.in_ready, round_done}); end
    tick();
    checks++; if ({lives, score, alu_y, bus.in_ready} !== {2'd2, 8'd255, 5'd0, 1'b1}) begin errors++; $display("FAIL tmo_result got lives=%0d score=%0d y=%0d rdy=%b want 2 255 0 1", lives, score, alu_y, bus.in_ready); end
    for (int i = 0; i < TMO - 1; i++) tick();
    bus.in_valid = 1'b1; bus.in_value = 5'd12; tick(); bus.in_valid = 1'b0;
    checks++; if ({alu_x, lives, bus.in_ready, round_done} !== {5'd12, 2'd2, 2'b10}) begin errors++; $display("FAIL tmo_accept_wins got x=%0d lives=%0d rdy=%b done=%b want 12 2 1 0", alu_x, lives, bus.in_ready, round_done); end
  endtask

  task automatic test_reset_in_eval();
    send(5'd3);
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if ({score, lives, alu_x, alu_y} !== 20'd0) begin errors++; $display("FAIL reval_data got %0d/%0d/%0d/%0d want 0/0/0/0", score, lives, alu_x, alu_y); end
    checks++; if ({bus.in_ready, round_done, game_over, busy} !== 4'b0000) begin errors++; $display("FAIL reval_flags got %b want 0000", {bus.in_ready, round_done, game_over, busy}); end
    force_lose = 1'b1; tick(); tick(); force_lose = 1'b0; tick();
    checks++; if ({lives, round_done, busy} !== 4'b0000) begin errors++; $display("FAIL reval_ignore got %b want 0000", {lives, round_done, busy}); end
  endtask

  task automatic test_start_handling();
    pulse_start();
    send(5'd5);
    pulse_start();
    checks++; if ({bus.in_ready, alu_x, lives, score} !== {1'b1, 5'd5, 2'd3, 8'd0}) begin errors++; $display("FAIL start_ignored got rdy=%b x=%0d lives=%0d score=%0d want 1 5 3 0", bus.in_ready, alu_x, lives, score); end
    send(5'd1); tick(); tick();
    checks++; if (score !== 8'd4) begin errors++; $display("FAIL start_round got %0d want 4", score); end
    play_round(5'd0, 5'd0);
    checks++; if ({score, lives} !== {8'd4, 2'd2}) begin errors++; $display("FAIL zero_lose got %0d/%0d want 4/2", score, lives); end
    play_round(5'd2, 5'd2);
    play_round(5'd9, 5'd9);
    tick(); tick(); tick();
    checks++; if ({game_over, lives, score} !== {1'b1, 2'd0, 8'd4}) begin errors++; $display("FAIL over_hold got go=%b lives=%0d score=%0d want 1 0 4", game_over, lives, score); end
    pulse_start();
    checks++; if ({game_over, busy, bus.in_ready, lives, score} !== {3'b011, 2'd3, 8'd0}) begin errors++; $display("FAIL restart got go=%b busy=%b rdy=%b lives=%0d score=%0d want 0 1 1 3 0", game_over, busy, bus.in_ready, lives, score); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    test_reset();
    test_first_round();
    test_lose_to_over();
    test_saturation();
    test_timeout();
    test_reset_in_eval();
    test_start_handling();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
